// File: rtl/lieat_exu_wbck_if.sv
// rtl/lieat_exu_wbck_if.sv - ALU/muldiv result inputs, commit handshake and register-file write port
interface lieat_exu_wbck_if #(
  parameter int XLEN    = 32,
  parameter int REG_IDX = 5
) ();
  logic               alu_i_valid;
  logic               alu_i_ready;
  logic [XLEN-1:0]    alu_i_pc;
  logic               alu_i_wen;
  logic [REG_IDX-1:0] alu_i_rd;
  logic [XLEN-1:0]    alu_i_data;

  logic               muldiv_i_valid;
  logic               muldiv_i_ready;
  logic [XLEN-1:0]    muldiv_i_pc;
  logic               muldiv_i_wen;
  logic [REG_IDX-1:0] muldiv_i_rd;
  logic [XLEN-1:0]    muldiv_i_data;
  logic               muldiv_i_flush;

  logic               wbck_o_valid;
  logic               wbck_o_ready;
  logic [XLEN-1:0]    wbck_o_pc;

  logic               rf_wen;
  logic [REG_IDX-1:0] rf_waddr;
  logic [XLEN-1:0]    rf_wdata;

  modport slave (
    input  alu_i_valid, alu_i_pc, alu_i_wen, alu_i_rd, alu_i_data,
    output alu_i_ready,
    input  muldiv_i_valid, muldiv_i_pc, muldiv_i_wen, muldiv_i_rd, muldiv_i_data, muldiv_i_flush,
    output muldiv_i_ready,
    output wbck_o_valid, wbck_o_pc,
    input  wbck_o_ready,
    output rf_wen, rf_waddr, rf_wdata
  );

  modport master (
    output alu_i_valid, alu_i_pc, alu_i_wen, alu_i_rd, alu_i_data,
    input  alu_i_ready,
    output muldiv_i_valid, muldiv_i_pc, muldiv_i_wen, muldiv_i_rd, muldiv_i_data, muldiv_i_flush,
    input  muldiv_i_ready,
    input  wbck_o_valid, wbck_o_pc,
    output wbck_o_ready,
    input  rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/lieat_exu_wbck.sv
// rtl/lieat_exu_wbck.sv - writeback arbiter between muldiv and ALU into one registered commit slot
module lieat_exu_wbck #(
  parameter int XLEN       = 32,
  parameter int REG_IDX    = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic            clock,
  input  logic            reset,
  lieat_exu_wbck_if.slave bus
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic               slot_valid;
  logic [XLEN-1:0]    slot_pc;
  logic               slot_wen;
  logic [REG_IDX-1:0] slot_rd;
  logic [XLEN-1:0]    slot_data;
  logic [3:0]         starve_cnt;

  logic slot_ready;
  logic muldiv_live;
  logic muldiv_drop;
  logic force_alu;
  logic grant_alu;
  logic grant_muldiv;
  logic load;

  // Flushed muldiv results are swallowed here and never compete for the slot.
  assign muldiv_drop  = bus.muldiv_i_valid & bus.muldiv_i_flush;
  assign muldiv_live  = bus.muldiv_i_valid & ~bus.muldiv_i_flush;
  assign slot_ready   = ~slot_valid | bus.wbck_o_ready;
  assign force_alu    = (starve_cnt == STARVE_LIM);
  assign grant_muldiv = slot_ready & muldiv_live & ~(bus.alu_i_valid & force_alu);
  assign grant_alu    = slot_ready & bus.alu_i_valid & (~muldiv_live | force_alu);
  assign load         = grant_alu | grant_muldiv;

  assign bus.alu_i_ready    = grant_alu;
  assign bus.muldiv_i_ready = grant_muldiv | muldiv_drop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid <= 1'b0;
      slot_pc    <= '0;
      slot_wen   <= 1'b0;
      slot_rd    <= '0;
      slot_data  <= '0;
    end else if (load) begin
      slot_valid <= 1'b1;
      slot_pc    <= grant_alu ? bus.alu_i_pc   : bus.muldiv_i_pc;
      slot_wen   <= grant_alu ? bus.alu_i_wen  : bus.muldiv_i_wen;
      slot_rd    <= grant_alu ? bus.alu_i_rd   : bus.muldiv_i_rd;
      slot_data  <= grant_alu ? bus.alu_i_data : bus.muldiv_i_data;
    end else if (slot_valid & bus.wbck_o_ready) begin
      slot_valid <= 1'b0;
    end
  end

  // Counts consecutive ALU losses; saturates so the forced grant stays armed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_alu) begin
      starve_cnt <= '0;
    end else if (bus.alu_i_valid & grant_muldiv & (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign bus.wbck_o_valid = slot_valid;
  assign bus.wbck_o_pc    = slot_valid ? slot_pc   : '0;
  assign bus.rf_waddr     = slot_valid ? slot_rd   : '0;
  assign bus.rf_wdata     = slot_valid ? slot_data : '0;
  assign bus.rf_wen       = slot_valid & bus.wbck_o_ready & slot_wen & (slot_rd != '0);
endmodule

// File: tb/tb_lieat_exu_wbck.sv
// tb/tb_lieat_exu_wbck.sv - directed scoreboard bench for lieat_exu_wbck
module tb_lieat_exu_wbck;
  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  ent_t exp_q[$];
  int   m_starve = 0;
  logic last_alu_grant;

  lieat_exu_wbck_if #(.XLEN(32), .REG_IDX(5)) bus ();

  lieat_exu_wbck #(.XLEN(32), .REG_IDX(5), .STARVE_MAX(STARVE_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.wbck_o_valid), 32'd0);
    chk({tag, "_rfwen"}, 32'(bus.rf_wen), 32'd0);
    chk({tag, "_waddr"}, 32'(bus.rf_waddr), 32'd0);
    chk({tag, "_wdata"}, bus.rf_wdata, 32'd0);
    chk({tag, "_pc"}, bus.wbck_o_pc, 32'd0);
  endtask

  // One clock of stimulus: drive, compare at the falling edge, update the model.
  task automatic step(input logic av, input logic [31:0] apc, input logic awen,
                      input logic [4:0] ard, input logic [31:0] adata,
                      input logic mv, input logic [31:0] mpc, input logic mwen,
                      input logic [4:0] mrd, input logic [31:0] mdata, input logic mfl,
                      input logic ordy);
    logic sr, md_live, frc, g_md, g_alu;
    ent_t e;
    bus.alu_i_valid    = av;   bus.alu_i_pc    = apc; bus.alu_i_wen    = awen;
    bus.alu_i_rd       = ard;  bus.alu_i_data  = adata;
    bus.muldiv_i_valid = mv;   bus.muldiv_i_pc = mpc; bus.muldiv_i_wen = mwen;
    bus.muldiv_i_rd    = mrd;  bus.muldiv_i_data = mdata; bus.muldiv_i_flush = mfl;
    bus.wbck_o_ready   = ordy;
    @(negedge clock);
    sr = (exp_q.size() == 0) | ordy;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("out_valid", 32'(bus.wbck_o_valid), 32'd1);
      chk("out_pc", bus.wbck_o_pc, e.pc);
      chk("rf_waddr", 32'(bus.rf_waddr), 32'(e.rd));
      chk("rf_wdata", bus.rf_wdata, e.data);
      chk("rf_wen", 32'(bus.rf_wen), 32'(ordy & e.wen & (e.rd != 5'd0)));
      if (ordy) void'(exp_q.pop_front());
    end else begin
      chk("idle_valid", 32'(bus.wbck_o_valid), 32'd0);
      chk("idle_rfwen", 32'(bus.rf_wen), 32'd0);
    end
    md_live = mv & ~mfl;
    frc     = (m_starve == STARVE_MAX);
    g_md    = sr & md_live & ~(av & frc);
    g_alu   = sr & av & (~md_live | frc);
    chk("alu_ready", 32'(bus.alu_i_ready), 32'(g_alu));
    chk("md_ready", 32'(bus.muldiv_i_ready), 32'(g_md | (mv & mfl)));
    last_alu_grant = g_alu;
    if (g_alu) exp_q.push_back('{pc: apc, wen: awen, rd: ard, data: adata});
    else if (g_md) exp_q.push_back('{pc: mpc, wen: mwen, rd: mrd, data: mdata});
    if (g_alu) m_starve = 0;
    else if (av & g_md & (m_starve < STARVE_MAX)) m_starve++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  initial begin
    reset = 1'b0;
    bus.alu_i_valid = 0; bus.alu_i_pc = 0; bus.alu_i_wen = 0; bus.alu_i_rd = 0; bus.alu_i_data = 0;
    bus.muldiv_i_valid = 0; bus.muldiv_i_pc = 0; bus.muldiv_i_wen = 0; bus.muldiv_i_rd = 0;
    bus.muldiv_i_data = 0; bus.muldiv_i_flush = 0; bus.wbck_o_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    reset = 1'b1;
    idle(1);

    // ALU-only stream, ten back-to-back results
    for (int i = 0; i < 10; i++)
      step(1, 32'h100 + 32'(i * 4), 1, 5'd3, 32'h1234, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);

    // Both requesters every cycle: muldiv x4 then ALU x1, repeating
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h200 + 32'(i), 1, 5'd10, 32'hA000 + 32'(i),
           1, 32'h300 + 32'(i), 1, 5'd11, 32'hB000 + 32'(i), 0, 1);
      chk("starve_seq", 32'(last_alu_grant), 32'((i % 5) == 4));
    end
    idle(1);
    idle(1);

    // Flushed muldiv against a full, stalled slot
    step(1, 32'h400, 1, 5'd9, 32'h9999, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h404, 1, 5'd7, 32'hDEAD, 1, 0);
    step(0, 0, 0, 0, 0, 1, 32'h404, 1, 5'd7, 32'hDEAD, 1, 0);
    idle(1);
    idle(1);

    // Flushed muldiv with a live ALU: ALU granted the same cycle
    step(1, 32'h500, 1, 5'd5, 32'h55, 1, 32'h504, 1, 5'd7, 32'hDEAD, 1, 1);
    idle(1);
    idle(1);

    // Write to x0 still commits but does not write the register file
    step(1, 32'h600, 1, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);

    // Stall three cycles, then reset asynchronously mid-hold
    step(1, 32'h80000010, 1, 5'd12, 32'hCAFE, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);
    idle(0);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    m_starve = 0;
    @(posedge clock);
    #1;
    check_outputs_zero("midreset_hold");
    reset = 1'b1;
    idle(1);
    step(1, 32'h700, 1, 5'd4, 32'h4444, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lieat_exu_wbck.md
Name: lieat_exu_wbck

Overview:
- Writeback stage directly downstream of the multiply/divide unit and the single-cycle ALU.
- Arbitrates their results into one registered writeback slot.
- Drives the integer register-file write port and a commit handshake.
- Drops results the muldiv unit has flagged as flushed, and includes an ALU anti-starvation counter.

Parameters:
XLEN, 32, datapath width
REG_IDX, 5, register index width
STARVE_MAX, 4, consecutive ALU losses after which the ALU gets forced priority (1..15)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
alu_i_valid  input  1  ALU result valid
alu_i_ready  output  1  ALU result accepted
alu_i_pc  input  XLEN  ALU instruction PC
alu_i_wen  input  1  ALU writes rd
alu_i_rd  input  REG_IDX  ALU destination
alu_i_data  input  XLEN  ALU result
muldiv_i_valid  input  1  muldiv result valid
muldiv_i_ready  output  1  muldiv result accepted
muldiv_i_pc  input  XLEN  muldiv PC
muldiv_i_wen  input  1  muldiv writes rd
muldiv_i_rd  input  REG_IDX  muldiv destination
muldiv_i_data  input  XLEN  muldiv result
muldiv_i_flush  input  1  muldiv result belongs to a flushed instruction
wbck_o_valid  output  1  committed result valid
wbck_o_ready  input  1  commit consumer accepts
wbck_o_pc  output  XLEN  committed PC
rf_wen  output  1  register-file write enable
rf_waddr  output  REG_IDX  write address
rf_wdata  output  XLEN  write data

Behaviour:
- Output slot
  - One-entry register holding valid, pc, wen, rd, data.
  - slot_ready = ~slot_valid | wbck_o_ready.
  - Load on any accepted input.
  - Clear on wbck_o_valid & wbck_o_ready with no new load.
  - Latency: input handshake in cycle N appears on outputs in cycle N+1.
  - No combinational path from inputs to wbck_o_*/rf_*.
- Reset (reset=0, async):
  - slot_valid=0, pc/rd/data/wen=0, starve_cnt=0.
  - Therefore wbck_o_valid=0, rf_wen=0, rf_waddr=0, rf_wdata=0, wbck_o_pc=0.
- Flushed muldiv results
  - muldiv_i_valid & muldiv_i_flush: muldiv_i_ready=1 unconditionally (even when the slot is full).
  - The result is discarded. It neither loads the slot nor counts as an arbitration win.
  - The ALU may be granted the slot in the same cycle.
- Arbitration among live requests (flushed muldiv excluded)
  - Only one valid: it wins if slot_ready.
  - Both valid: muldiv wins, unless starve_cnt == STARVE_MAX, in which case the ALU wins.
  - Loser's ready=0; it holds its request.
  - slot_ready=0: both readies 0, except the flush drop.
- starve_cnt (4 bits)
  - Increments when the ALU is valid, the muldiv wins and slot_ready=1.
  - Resets to 0 when the ALU is granted.
  - Holds otherwise.
  - Saturates at STARVE_MAX.
- Register-file write
  - rf_wen = wbck_o_valid & wbck_o_ready & slot_wen & (slot_rd != 0).
  - rf_waddr = slot_rd, rf_wdata = slot_data whenever slot_valid, else 0.
  - Writes to x0 are suppressed, but the entry still commits.
- Simultaneous drain and load: the slot is replaced in the same cycle, giving back-to-back throughput of 1/cycle.
- Backpressure: wbck_o_ready=0 holds all slot contents stable while wbck_o_valid=1.
- Mid-operation reset: clears the slot without writing the register file. The starvation counter clears.

Test Plan:
- ALU only: alu_i_valid=1, rd=3, data=0x1234, wbck_o_ready=1 -> next cycle rf_wen=1, rf_waddr=3, rf_wdata=0x1234, alu_i_ready=1 every cycle for 10 back-to-back results.
- Both valid each cycle, STARVE_MAX=4, ready=1 -> grant sequence is muldiv ×4, ALU ×1, repeating; starve_cnt returns to 0 after each ALU grant.
- muldiv_i_flush=1 with rd=7, data=0xDEAD while slot full and wbck_o_ready=0 -> muldiv_i_ready=1, no slot change, rf_wen never pulses for rd 7.
- Flushed muldiv and ALU (rd=5, data=0x55) valid together -> ALU granted the same cycle; next cycle rf_waddr=5, rf_wdata=0x55.
- Write to x0: ALU rd=0, wen=1 -> wbck_o_valid=1 for one cycle, rf_wen=0.
- Hold wbck_o_ready=0 for 3 cycles with slot pc=0x80000010, then drop reset mid-hold -> outputs stable for 3 cycles, then immediately 0 on reset assertion; no rf_wen pulse.
